// File: rtl/mrd_source_scaler.sv
// mrd_source_scaler
// Post-processing stage for a block-floating-point DFT output stream.
// Each beat's 18-bit real/imag mantissas are shifted left by the frame exponent,
// rounded by dropping DROP LSBs and saturated to OUT_W bits. The block also
// checks frame delimiters, counts beats per frame and reports clipping per frame.
// Pipeline: stage 1 (_p0) = framing + exponent shift, stage 2 = round/saturate
// into the output registers. Latency is fixed at two cycles, with no backpressure.
module mrd_source_scaler #(
    parameter int OUT_W = 16,
    parameter int DROP  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sop,
    input  logic                    in_eop,
    input  logic signed [17:0]      in_real,
    input  logic signed [17:0]      in_imag,
    input  logic [3:0]              in_exp,
    output logic                    out_valid,
    output logic                    out_sop,
    output logic                    out_eop,
    output logic signed [OUT_W-1:0] out_real,
    output logic signed [OUT_W-1:0] out_imag,
    output logic [11:0]             out_frame_len,
    output logic                    out_sat,
    output logic                    err_pulse
);

    // 18-bit mantissa shifted by up to 15 fits in 34 bits; one extra bit keeps
    // the rounding offset addition free of overflow.
    localparam int EXT_W  = 34;
    localparam int RND_W  = EXT_W + 1;
    localparam int RND_SH = (DROP > 0) ? DROP - 1 : 0;

    localparam logic signed [RND_W-1:0] RND  = (DROP > 0) ? (RND_W'(1) <<< RND_SH) : '0;
    localparam logic signed [RND_W-1:0] MAXV = (RND_W'(1) <<< (OUT_W - 1)) - RND_W'(1);
    localparam logic signed [RND_W-1:0] MINV = -(RND_W'(1) <<< (OUT_W - 1));

    localparam logic [11:0] CNT_MAX = 12'hFFF;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } state_t;

    // Round half up toward +inf by adding half an output LSB before the
    // arithmetic right shift; with DROP=0 the value passes through unchanged.
    function automatic logic signed [RND_W-1:0] round_drop(input logic signed [EXT_W-1:0] x);
        logic signed [RND_W-1:0] xw;
        xw = {x[EXT_W-1], x};
        return (xw + RND) >>> DROP;
    endfunction

    // True when the rounded value lies outside the OUT_W signed range.
    function automatic logic clips(input logic signed [RND_W-1:0] x);
        return (x > MAXV) || (x < MINV);
    endfunction

    // Clamp the rounded value to the OUT_W signed range.
    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [RND_W-1:0] x);
        logic signed [RND_W-1:0] y;
        if (x > MAXV) begin
            y = MAXV;
        end else if (x < MINV) begin
            y = MINV;
        end else begin
            y = x;
        end
        return y[OUT_W-1:0];
    endfunction

    state_t                  state_q, state_d;
    logic [11:0]             count_q, cnt_d, cnt_inc;
    logic [3:0]              exp_q, exp_d, use_exp;
    logic                    fwd, f_sop, f_eop, f_err;
    logic [11:0]             f_len;
    logic signed [EXT_W-1:0] ext_re, ext_im;

    logic                    vld_p0, sop_p0, eop_p0, err_p0;
    logic [11:0]             len_p0;
    logic signed [EXT_W-1:0] real_p0, imag_p0;

    logic signed [RND_W-1:0] rnd_re, rnd_im;
    logic                    beat_sat, sticky_p1, frame_sat;

    assign cnt_inc = (count_q == CNT_MAX) ? CNT_MAX : count_q + 12'd1;
    assign ext_re  = {{(EXT_W - 18){in_real[17]}}, in_real};
    assign ext_im  = {{(EXT_W - 18){in_imag[17]}}, in_imag};

    // Framing decisions and next FSM state; nothing changes without in_valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = count_q;
        exp_d   = exp_q;
        use_exp = exp_q;
        fwd     = 1'b0;
        f_sop   = 1'b0;
        f_eop   = 1'b0;
        f_err   = 1'b0;
        f_len   = '0;
        if (in_valid) begin
            if (in_sop) begin
                // A sop inside a frame abandons the old frame and flags it.
                f_err   = (state_q == IN_FRAME);
                fwd     = 1'b1;
                f_sop   = 1'b1;
                use_exp = in_exp;
                exp_d   = in_exp;
                if (in_eop) begin
                    f_eop   = 1'b1;
                    f_len   = 12'd1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d   = 12'd1;
                    state_d = IN_FRAME;
                end
            end else if (state_q == IDLE) begin
                // Beat outside any frame: dropped, only the error is reported.
                f_err = 1'b1;
            end else begin
                fwd = 1'b1;
                if (in_eop) begin
                    f_eop   = 1'b1;
                    f_len   = cnt_inc;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    // Stage 1 boundary: FSM, beat counter, latched exponent and beat qualifiers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            exp_q   <= '0;
            vld_p0  <= 1'b0;
            sop_p0  <= 1'b0;
            eop_p0  <= 1'b0;
            err_p0  <= 1'b0;
            len_p0  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= cnt_d;
            exp_q   <= exp_d;
            vld_p0  <= fwd;
            sop_p0  <= f_sop;
            eop_p0  <= f_eop;
            err_p0  <= f_err;
            len_p0  <= f_len;
        end
    end

    // Stage 1 boundary: exponent-shifted mantissas (data path, no reset).
    always_ff @(posedge clk) begin
        real_p0 <= ext_re <<< use_exp;
        imag_p0 <= ext_im <<< use_exp;
    end

    assign rnd_re    = round_drop(real_p0);
    assign rnd_im    = round_drop(imag_p0);
    assign beat_sat  = clips(rnd_re) || clips(rnd_im);
    // The sticky flag belongs to the previous frame when this beat is a sop.
    assign frame_sat = beat_sat || (!sop_p0 && sticky_p1);

    // Stage 2 boundary: output qualifiers, frame length and per-frame clip flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_sop       <= 1'b0;
            out_eop       <= 1'b0;
            err_pulse     <= 1'b0;
            out_frame_len <= '0;
            out_sat       <= 1'b0;
            sticky_p1     <= 1'b0;
        end else begin
            out_valid     <= vld_p0;
            out_sop       <= vld_p0 && sop_p0;
            out_eop       <= vld_p0 && eop_p0;
            err_pulse     <= err_p0;
            out_frame_len <= (vld_p0 && eop_p0) ? len_p0 : '0;
            out_sat       <= vld_p0 && eop_p0 && frame_sat;
            if (vld_p0) begin
                sticky_p1 <= frame_sat;
            end
        end
    end

    // Stage 2 boundary: rounded, saturated samples; zero whenever no beat is out.
    always_ff @(posedge clk) begin
        out_real <= (vld_p0 && !rst) ? saturate(rnd_re) : '0;
        out_imag <= (vld_p0 && !rst) ? saturate(rnd_im) : '0;
    end

endmodule

// File: tb/tb_mrd_source_scaler.sv
// Testbench for mrd_source_scaler: scenario tasks drive beats and push the
// expected output of each cycle into a scoreboard queue; a negedge monitor
// pops and compares when that cycle's output is due.
module tb_mrd_source_scaler;

    localparam int OUT_W = 16;
    localparam int DROP  = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_sop = 1'b0;
    logic                    in_eop = 1'b0;
    logic signed [17:0]      in_real = '0;
    logic signed [17:0]      in_imag = '0;
    logic [3:0]              in_exp = '0;
    logic                    out_valid, out_sop, out_eop, out_sat, err_pulse;
    logic signed [OUT_W-1:0] out_real, out_imag;
    logic [11:0]             out_frame_len;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int due;
        bit v, s, e, err, sat;
        int len;
        int re, im;
    } rec_t;

    rec_t q[$];

    // Reference framing state
    bit m_in;
    int m_cnt, m_exp;
    bit m_sticky;

    mrd_source_scaler #(.OUT_W(OUT_W), .DROP(DROP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
        .in_real(in_real), .in_imag(in_imag), .in_exp(in_exp),
        .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_real(out_real), .out_imag(out_imag),
        .out_frame_len(out_frame_len), .out_sat(out_sat), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int scale(input int m, input int ex, output bit c);
        longint v, hi, lo;
        v  = longint'(m) * (longint'(1) << ex);
        if (DROP > 0) v = (v + (longint'(1) << (DROP - 1))) >>> DROP;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        c  = 1'b0;
        if (v > hi) begin v = hi; c = 1'b1; end
        else if (v < lo) begin v = lo; c = 1'b1; end
        return int'(v);
    endfunction

    task automatic drive(input bit vv, input bit ss, input bit ee,
                         input int re, input int im, input int ex);
        rec_t r;
        bit fwd, cr, ci;
        @(negedge clk);
        rst = 1'b0; in_valid = vv; in_sop = ss; in_eop = ee;
        in_real = re[17:0]; in_imag = im[17:0]; in_exp = ex[3:0];
        r = '{default: 0};
        r.due = cyc + 2;
        fwd = 1'b0;
        if (vv) begin
            if (ss) begin
                r.err = m_in; m_exp = ex & 15; m_sticky = 1'b0; fwd = 1'b1;
                if (ee) begin r.e = 1'b1; r.len = 1; m_in = 1'b0; end
                else begin m_in = 1'b1; m_cnt = 1; end
            end else if (!m_in) begin
                r.err = 1'b1;
            end else begin
                fwd = 1'b1;
                if (ee) begin
                    r.e = 1'b1; r.len = (m_cnt >= 4095) ? 4095 : m_cnt + 1; m_in = 1'b0;
                end else if (m_cnt < 4095) begin
                    m_cnt++;
                end
            end
            if (fwd) begin
                r.v = 1'b1; r.s = ss;
                r.re = scale(re, m_exp, cr);
                r.im = scale(im, m_exp, ci);
                m_sticky = m_sticky | cr | ci;
                if (r.e) r.sat = m_sticky;
            end
        end
        q.push_back(r);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rec_t r;
        repeat (n) begin
            @(negedge clk);
            rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
            while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
            r = '{default: 0};
            r.due = cyc + 1;
            q.push_back(r);
        end
        m_in = 1'b0; m_cnt = 0; m_exp = 0; m_sticky = 1'b0;
    endtask

    // Scoreboard monitor: compares every due cycle's outputs.
    always @(negedge clk) begin
        rec_t r;
        while (q.size() > 0 && q[0].due < cyc) begin
            r = q.pop_front();
            checks++; failures++;
            $display("FAIL stale_entry due=%0d now=%0d", r.due, cyc);
        end
        while (q.size() > 0 && q[0].due == cyc) begin
            r = q.pop_front();
            checks++;
            if ({out_valid, out_sop, out_eop, err_pulse} !== {r.v, r.s, r.e, r.err}) begin
                failures++;
                $display("FAIL ctrl cyc=%0d got vld/sop/eop/err=%b want=%b", cyc,
                         {out_valid, out_sop, out_eop, err_pulse}, {r.v, r.s, r.e, r.err});
            end
            checks++;
            if (out_real !== OUT_W'(r.re)) begin
                failures++;
                $display("FAIL out_real cyc=%0d got=%0d want=%0d", cyc, out_real, r.re);
            end
            checks++;
            if (out_imag !== OUT_W'(r.im)) begin
                failures++;
                $display("FAIL out_imag cyc=%0d got=%0d want=%0d", cyc, out_imag, r.im);
            end
            checks++;
            if (out_frame_len !== 12'(r.len)) begin
                failures++;
                $display("FAIL frame_len cyc=%0d got=%0d want=%0d", cyc, out_frame_len, r.len);
            end
            checks++;
            if (out_sat !== r.sat) begin
                failures++;
                $display("FAIL out_sat cyc=%0d got=%b want=%b", cyc, out_sat, r.sat);
            end
        end
    end

    task automatic test_reset();
        do_reset(2);
        drive(1, 1, 0, 500, -500, 2);
        drive(1, 0, 0, 700, 3, 5);
        do_reset(1);
        repeat (2) begin
            do_reset(1);
            checks++;
            if ({out_valid, out_sop, out_eop, err_pulse, out_sat, out_frame_len, out_real, out_imag} !== '0) begin
                failures++;
                $display("FAIL reset_outputs got vld=%b sop=%b eop=%b err=%b real=%0d want all zero",
                         out_valid, out_sop, out_eop, err_pulse, out_real);
            end
        end
        idle(3);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) drive(1, i == 0, i == 7, 16 + i, -16 - i, 0);
        idle(3);
    endtask

    task automatic test_single_sat();
        drive(1, 1, 1, 131071, -131072, 15);
        idle(2);
        checks++;
        if (out_real !== 16'sd32767 || out_sat !== 1'b1 || out_frame_len !== 12'd1) begin
            failures++;
            $display("FAIL single_sat got real=%0d sat=%b len=%0d want 32767 1 1",
                     out_real, out_sat, out_frame_len);
        end
        idle(2);
    endtask

    task automatic test_latched_exp();
        drive(1, 1, 0, 0, 1, 3);
        drive(1, 0, 0, -2, 2, 9);
        drive(1, 0, 0, -2, 3, 9);
        drive(1, 0, 1, -2, -3, 9);
        idle(3);
    endtask

    task automatic test_orphan();
        drive(1, 0, 0, 1000, 1000, 4);
        drive(1, 0, 1, 1000, 1000, 4);
        drive(1, 1, 0, 32, 48, 1);
        drive(1, 0, 0, 64, 80, 0);
        drive(1, 0, 1, 96, 112, 0);
        idle(3);
    endtask

    task automatic test_restart();
        for (int i = 0; i < 5; i++) drive(1, i == 0, 0, 100 * i, -100 * i, 6);
        for (int i = 0; i < 4; i++) drive(1, i == 0, i == 3, 9 * i, 7 * i, 2);
        idle(3);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1, i == 0, 0, 40 + i, 50 + i, 1);
        do_reset(2);
        for (int i = 0; i < 4; i++) drive(1, i == 0, i == 3, 300 * i - 400, 11 * i, 3);
        idle(3);
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 10; i++) begin
            drive(1, i == 0, i == 9, 1000 * i - 5000, 77 * i, 5);
            if (i % 3 == 1) idle(1 + i % 2);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 0, 10, 10, 1);
        drive(1, 0, 0, 100000, 5, 1);
        drive(1, 0, 1, 20, 20, 1);
        drive(1, 1, 1, 30, 30, 2);
        drive(1, 1, 0, 40, -40, 0);
        drive(1, 0, 1, 50, -50, 0);
        idle(3);
    endtask

    task automatic test_len_sat();
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4098; i++) drive(1, 0, 0, i % 1000, 0, 0);
        drive(1, 0, 1, 0, 0, 0);
        idle(2);
        checks++;
        if (out_frame_len !== 12'd4095 || out_eop !== 1'b1) begin
            failures++;
            $display("FAIL len_sat got len=%0d eop=%b want 4095 1", out_frame_len, out_eop);
        end
        idle(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                  int'($urandom_range(0, 262143)) - 131072, int'($urandom_range(0, 262143)) - 131072,
                  int'($urandom_range(0, 15)));
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_sat();
        test_latched_exp();
        test_orphan();
        test_restart();
        test_reset_mid();
        test_gaps();
        test_back_to_back();
        test_len_sat();
        test_random();
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 6 && q.size() > 0; i++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mrd_source_scaler.md
MRD_SOURCE_SCALER -- requirements
Module: mrd_source_scaler

Interface
REQ-001 Parameter: OUT_W, 16, signed width of scaled output real/imag (range 8..24).
REQ-002 Parameter: DROP, 4, number of LSBs removed by rounding after exponent shift (range 0..12).
REQ-003 Port: clk  input  1  single clock; all logic rising-edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  sample beat valid; driven from the DFT core's source_valid; no backpressure exists.
REQ-006 Port: in_sop / in_eop  input  1 each  first / last beat of a DFT output frame.
REQ-007 Port: in_real / in_imag  input  18 each  signed two's-complement block-floating-point mantissas.
REQ-008 Port: in_exp  input  4  unsigned frame exponent; sampled only on the sop beat.
REQ-009 Port: out_valid / out_sop / out_eop  output  1 each  registered beat qualifiers.
REQ-010 Port: out_real / out_imag  output  OUT_W each  signed scaled, rounded, saturated samples.
REQ-011 Port: out_frame_len  output  12  beat count of the frame; valid only on the out_eop beat, else 0.
REQ-012 Port: out_sat  output  1  on the out_eop beat: 1 if any real or imag sample of that frame saturated; else 0.
REQ-013 Port: err_pulse  output  1  one-cycle pulse on a framing error.

Function
REQ-014 Two-state FSM: IDLE, IN_FRAME; state updates only on in_valid beats.
REQ-015 IDLE + valid&sop&~eop -> IN_FRAME; latch in_exp; beat count=1; beat forwarded with out_sop=1.
REQ-016 IDLE + valid&sop&eop -> single-beat frame; stays IDLE; forwarded with out_sop=out_eop=1; frame_len=1.
REQ-017 IDLE + valid&~sop -> beat dropped (no out_valid); err_pulse=1 at the cycle the beat would have emerged.
REQ-018 IN_FRAME + valid&~sop&~eop -> forwarded; count increments; count saturates at 4095.
REQ-019 IN_FRAME + valid&eop&~sop -> forwarded with out_eop=1, out_frame_len=count+1 (saturated), out_sat=sticky|this beat; -> IDLE.
REQ-020 IN_FRAME + valid&sop -> err_pulse; old frame abandoned (no eop emitted); new frame started per REQ-015/016 using new in_exp.
REQ-021 Non-sop beats use the latched exponent; in_exp is ignored on them.
REQ-022 Arithmetic per component: sign-extend 18-bit mantissa to 34 bits, shift left by exp (0..15), no overflow possible at 34 bits.
REQ-023 If DROP>0: add 2^(DROP-1), then arithmetic right shift by DROP (round half up toward +inf); DROP=0: no rounding.
REQ-024 Saturate result to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; any clipping sets per-frame sticky flag; sticky cleared at every sop.
REQ-025 Latency exactly 2 cycles in_valid -> out_valid; stage 1 = framing + shift, stage 2 = round + saturate + register.
REQ-026 Throughput one beat per cycle; gaps in in_valid are passed through as gaps of identical length.
REQ-027 When out_valid=0: out_real, out_imag, out_frame_len, out_sat, out_sop, out_eop all 0.
REQ-028 err_pulse is aligned to the output timeline (2 cycles after the offending input beat) and is independent of out_valid.

Reset
REQ-029 While rst=1: all outputs 0, FSM=IDLE, count=0, latched exp=0, sticky=0, pipeline valids cleared.
REQ-030 Reset asserted mid-frame discards all in-flight beats; no out_eop/err_pulse emitted for the aborted frame.
REQ-031 First input beat sampled in the cycle after rst deasserts is processed normally.

Verification
REQ-032 8-beat frame, exp=0, real=16..23, DROP=4, OUT_W=16 -> out real=1,1,1,1,1,1,1,1 (16+8>>4=1, 23+8>>4=1), frame_len=8, out_sat=0, latency 2.
REQ-033 Single beat sop&eop, real=131071, exp=15 -> out_real=32767, out_sop=out_eop=1, frame_len=1, out_sat=1.
REQ-034 Frame: sop beat exp=3, next beats in_exp=9 with real=-2 -> out_real=-1 ((-16+8)>>4=-1), confirming latched exp=3.
REQ-035 Beat with valid&~sop in IDLE -> no out_valid, err_pulse 2 cycles later; following valid frame unaffected.
REQ-036 sop at beat 5 of a frame -> err_pulse, no eop for first frame, new frame's out_frame_len counts from its own sop.
REQ-037 rst asserted at beat 3 of 10-beat frame, released, new 4-beat frame -> no output for old frame, new frame_len=4.
